flit_age_stamper: RTL and testbench
===================================

Name: flit_age_stamper

Overview:
- Router injection stage that sits in front of the 4-lane age-sorting permutation network.
- It writes the age timestamp (POS_TIME field) that the network's arbiters later read.
- Buffers locally injected flits in a FIFO, stamping each one with the global time at acceptance.
- Each cycle it inserts the head flit into the lowest-index idle lane, then registers all 4 lanes toward the permutation network.

Parameters:
WIDTH, 64, flit width in bits including the time field
TIME_LSB, 48, bit position of time field LSB within flit
TIME_W, 8, time field / global counter width
DEPTH, 4, injection FIFO entries (power of 2, >=2)
STARVE_LIMIT, 16, consecutive blocked cycles before starve flag asserts

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
lane_in  in  4*WIDTH  in-network flits, lane i at [i*WIDTH +: WIDTH]
lane_vld_in  in  4  lane i carries a flit
inj_flit  in  WIDTH  local injection flit (time field ignored)
inj_valid  in  1  injection request
inj_ready  out  1  FIFO can accept
lane_out  out  4*WIDTH  registered lanes to permutation network
lane_vld_out  out  4  registered lane valids
fifo_count  out  log2(DEPTH)+1  current FIFO occupancy
time_now  out  TIME_W  global time counter
starve  out  1  injection blocked >= STARVE_LIMIT cycles

Behaviour:
- Clock and reset: one clock. rst_n is asynchronous and active-low.
- Reset values: all outputs and state 0, except inj_ready, which is 1 (FIFO empty). Reset asserted mid-operation flushes the FIFO, clears lanes, the counter and the starve counter. Flits in flight are lost.
- time_now: increments by 1 every cycle and wraps modulo 2^TIME_W. Smaller value = older. Wrap ordering is the arbiter's concern.
- Push: happens when inj_valid & inj_ready. The FIFO stores inj_flit with bits [TIME_LSB +: TIME_W] replaced by time_now of the push cycle.
- inj_ready: combinational, equals (fifo_count < DEPTH), based on registered count only. It does not depend on a same-cycle pop, so a full FIFO refuses input even when it is popping.
- Free lanes: free = ~lane_vld_in.
- Pop condition: FIFO non-empty and free != 0. The head goes to the lowest-index free lane k.
  - At most one pop per cycle.
  - The timestamp is not rewritten at pop.
- No bypass: a flit pushed in cycle t can pop in cycle t+1 at the earliest.
- Simultaneous push and pop: legal when 0 < count < DEPTH. Count is unchanged.
- Pointers: wrap modulo DEPTH.
- Output register: 1-cycle latency. Each cycle:
  - lane_out[i] <= lane_in[i] if lane_vld_in[i].
  - Otherwise lane_out[i] <= the popped flit if i == k.
  - Otherwise lane_out[i] <= 0.
  - lane_vld_out is updated to match. Network flits pass through unmodified, time field included.
- Starve counter:
  - Increments each cycle that the FIFO is non-empty and free == 0.
  - Saturates at STARVE_LIMIT.
  - Clears on any pop or when the FIFO is empty.
  - starve = (counter == STARVE_LIMIT), registered.
- Empty FIFO with free lanes: idle lanes output 0 with valid 0.
- lane_in data on invalid lanes is ignored (it may be X).

Test Plan:
- Reset release, inj_valid=0, lane_vld_in=4'b0000 for 5 cycles -> time_now counts 0..4; lane_vld_out=0; inj_ready=1; fifo_count=0.
- Single inject at time_now=3, all lanes free -> next cycle fifo_count=1; following cycle lane_vld_out=4'b0001 and lane_out[0] time field=3; fifo_count=0.
- lane_vld_in=4'b1011, FIFO holds 2 flits -> head lands in lane 2, lane 0/1/3 data pass through unchanged; next cycle head goes to lane 2 again if still free.
- inj_valid held high, lane_vld_in=4'b1111, DEPTH=4 -> 4 pushes, then inj_ready=0 and fifo_count=4; starve=1 exactly STARVE_LIMIT cycles after first blocked cycle; freeing lane 3 pops one, starve clears next cycle, count=3.
- Counter wrap: TIME_W=8, push at time_now=255 and 0 -> stamps 255 then 0; counter wraps without glitch.
- Assert rst_n low mid-operation with FIFO count 3 and lanes valid -> outputs clear immediately (async); after release FIFO is empty, time_now restarts at 0.

Source files
------------

// File: rtl/flit_age_stamper.sv
// Injection stage ahead of the 4-lane age-sorting network: queues local flits
// stamped with the global time and drops the head into the lowest idle lane.
module flit_age_stamper #(
    parameter int WIDTH        = 64,
    parameter int TIME_LSB     = 48,
    parameter int TIME_W       = 8,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*WIDTH-1:0]     lane_in,
    input  logic [3:0]             lane_vld_in,
    input  logic [WIDTH-1:0]       inj_flit,
    input  logic                   inj_valid,
    output logic                   inj_ready,
    output logic [4*WIDTH-1:0]     lane_out,
    output logic [3:0]             lane_vld_out,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [TIME_W-1:0]      time_now,
    output logic                   starve
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [SW-1:0]      starve_cnt;
    logic [SW-1:0]      starve_cnt_nxt;
    logic [3:0]         free;
    logic [3:0]         grant;
    logic               push;
    logic               pop;
    logic [WIDTH-1:0]   stamped;
    logic [WIDTH-1:0]   head;
    logic [4*WIDTH-1:0] lane_nxt;
    logic [3:0]         vld_nxt;

    assign free      = ~lane_vld_in;
    // Isolate the lowest set bit: the one lane the head flit may claim.
    assign grant     = free & (~free + 4'd1);
    assign inj_ready = (fifo_count < CW'(DEPTH));
    assign push      = inj_valid & inj_ready;
    assign pop       = (fifo_count != '0) && (free != 4'b0000);
    assign head      = mem[rd_ptr];

    always_comb begin
        stamped = inj_flit;
        stamped[TIME_LSB +: TIME_W] = time_now;
    end

    always_comb begin
        lane_nxt = '0;
        vld_nxt  = '0;
        for (int i = 0; i < 4; i++) begin
            if (lane_vld_in[i]) begin
                lane_nxt[i*WIDTH +: WIDTH] = lane_in[i*WIDTH +: WIDTH];
                vld_nxt[i]                 = 1'b1;
            end else if (pop && grant[i]) begin
                lane_nxt[i*WIDTH +: WIDTH] = head;
                vld_nxt[i]                 = 1'b1;
            end
        end
    end

    // A non-empty FIFO that cannot pop is blocked solely because every lane is busy.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if ((fifo_count == '0) || pop) begin
            starve_cnt_nxt = '0;
        end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_cnt_nxt = starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= stamped;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_out     <= '0;
            lane_vld_out <= '0;
            time_now     <= '0;
            starve_cnt   <= '0;
            starve       <= 1'b0;
        end else begin
            lane_out     <= lane_nxt;
            lane_vld_out <= vld_nxt;
            time_now     <= time_now + TIME_W'(1);
            starve_cnt   <= starve_cnt_nxt;
            starve       <= (starve_cnt_nxt == SW'(STARVE_LIMIT));
        end
    end

endmodule

// File: tb/tb_flit_age_stamper.sv
// Bench for flit_age_stamper: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a queue-based model.
module tb_flit_age_stamper;

    localparam int WIDTH        = 64;
    localparam int TIME_LSB     = 48;
    localparam int TIME_W       = 8;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 16;

    logic                 clk;
    logic                 rst_n;
    logic [4*WIDTH-1:0]   lane_in;
    logic [3:0]           lane_vld_in;
    logic [WIDTH-1:0]     inj_flit;
    logic                 inj_valid;
    logic                 inj_ready;
    logic [4*WIDTH-1:0]   lane_out;
    logic [3:0]           lane_vld_out;
    logic [2:0]           fifo_count;
    logic [TIME_W-1:0]    time_now;
    logic                 starve;

    int checks = 0;
    int errors = 0;

    // Reference model state: queue of stamped flits plus plain integers.
    logic [WIDTH-1:0] m_q[$];
    int               m_time;
    int               m_scnt;
    logic [WIDTH-1:0] m_lane[4];
    logic [3:0]       m_vld;

    typedef struct {
        logic [3:0] lv;
        logic       iv;
        int         exp_time;
        int         exp_count;
        logic [3:0] exp_vld;
        int         stamp_lane;
        int         exp_stamp;
    } vec_t;

    vec_t vecs[9];

    flit_age_stamper #(
        .WIDTH(WIDTH), .TIME_LSB(TIME_LSB), .TIME_W(TIME_W),
        .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .lane_in(lane_in),
        .lane_vld_in(lane_vld_in),
        .inj_flit(inj_flit),
        .inj_valid(inj_valid),
        .inj_ready(inj_ready),
        .lane_out(lane_out),
        .lane_vld_out(lane_vld_out),
        .fifo_count(fifo_count),
        .time_now(time_now),
        .starve(starve)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] stamp_of(input int lane);
        logic [4*WIDTH-1:0] tmp;
        tmp = lane_out;
        return tmp[lane*WIDTH + TIME_LSB +: TIME_W];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_time = 0;
        m_scnt = 0;
        m_vld  = '0;
        for (int i = 0; i < 4; i++) m_lane[i] = '0;
    endtask

    task automatic check_output();
        check_val("time_now", 64'(time_now), 64'(m_time));
        check_val("fifo_count", 64'(fifo_count), 64'(m_q.size()));
        check_val("inj_ready", 64'(inj_ready), 64'(m_q.size() < DEPTH));
        check_val("lane_vld_out", 64'(lane_vld_out), 64'(m_vld));
        check_val("starve", 64'(starve), 64'(m_scnt == STARVE_LIMIT));
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("lane_out[%0d]", i), lane_out[i*WIDTH +: WIDTH], m_lane[i]);
        end
    endtask

    // Drive one cycle of inputs (random payloads), advance the model, check after the edge.
    task automatic apply_stimulus(input logic [3:0] lv, input logic iv);
        int               sz;
        int               k;
        logic             pop_m;
        logic             push_m;
        logic [WIDTH-1:0] st;
        lane_in     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        inj_flit    = {$urandom, $urandom};
        lane_vld_in = lv;
        inj_valid   = iv;

        sz    = m_q.size();
        pop_m = (sz > 0) && (lv != 4'hF);
        k     = -1;
        for (int i = 0; i < 4; i++) if (!lv[i] && k < 0) k = i;
        for (int i = 0; i < 4; i++) begin
            if (lv[i]) begin
                m_lane[i] = lane_in[i*WIDTH +: WIDTH];
                m_vld[i]  = 1'b1;
            end else if (pop_m && i == k) begin
                m_lane[i] = m_q[0];
                m_vld[i]  = 1'b1;
            end else begin
                m_lane[i] = '0;
                m_vld[i]  = 1'b0;
            end
        end
        if (sz == 0 || pop_m) m_scnt = 0;
        else if (m_scnt < STARVE_LIMIT) m_scnt = m_scnt + 1;
        push_m = iv && (sz < DEPTH);
        st = inj_flit;
        st[TIME_LSB +: TIME_W] = m_time[TIME_W-1:0];
        if (pop_m) void'(m_q.pop_front());
        if (push_m) m_q.push_back(st);
        m_time = (m_time + 1) % (1 << TIME_W);

        @(posedge clk);
        @(negedge clk);
        check_output();
    endtask

    initial begin
        int guard;
        clk         = 0;
        rst_n       = 0;
        lane_in     = '0;
        lane_vld_in = '0;
        inj_flit    = '0;
        inj_valid   = 0;
        model_reset();

        vecs[0] = '{4'b0000, 1'b0, 1, 0, 4'b0000, -1, 0};
        vecs[1] = '{4'b0000, 1'b0, 2, 0, 4'b0000, -1, 0};
        vecs[2] = '{4'b0000, 1'b0, 3, 0, 4'b0000, -1, 0};
        vecs[3] = '{4'b0000, 1'b1, 4, 1, 4'b0000, -1, 0};
        vecs[4] = '{4'b0000, 1'b0, 5, 0, 4'b0001,  0, 3};
        vecs[5] = '{4'b1111, 1'b1, 6, 1, 4'b1111, -1, 0};
        vecs[6] = '{4'b1111, 1'b1, 7, 2, 4'b1111, -1, 0};
        vecs[7] = '{4'b1011, 1'b0, 8, 1, 4'b1111,  2, 5};
        vecs[8] = '{4'b1011, 1'b0, 9, 0, 4'b1111,  2, 6};

        repeat (2) @(negedge clk);
        check_output();
        rst_n = 1;
        check_val("time_after_release", 64'(time_now), 64'd0);

        for (int v = 0; v < 9; v++) begin
            apply_stimulus(vecs[v].lv, vecs[v].iv);
            check_val($sformatf("vec%0d_time", v), 64'(time_now), 64'(vecs[v].exp_time));
            check_val($sformatf("vec%0d_count", v), 64'(fifo_count), 64'(vecs[v].exp_count));
            check_val($sformatf("vec%0d_vld", v), 64'(lane_vld_out), 64'(vecs[v].exp_vld));
            if (vecs[v].stamp_lane >= 0)
                check_val($sformatf("vec%0d_stamp", v), 64'(stamp_of(vecs[v].stamp_lane)),
                          64'(vecs[v].exp_stamp));
        end

        // Fill while all lanes busy, reach starvation, then release one lane.
        for (int n = 1; n <= 20; n++) begin
            apply_stimulus(4'b1111, 1'b1);
            if (n == 4) begin
                check_val("full_count", 64'(fifo_count), 64'd4);
                check_val("full_ready", 64'(inj_ready), 64'd0);
            end
            if (n == 16) check_val("starve_before_limit", 64'(starve), 64'd0);
            if (n == 17) check_val("starve_at_limit", 64'(starve), 64'd1);
        end
        apply_stimulus(4'b0111, 1'b1);
        check_val("release_count", 64'(fifo_count), 64'd3);
        check_val("release_starve", 64'(starve), 64'd0);
        check_val("release_lane3_stamp", 64'(stamp_of(3)), 64'd9);

        // Drain, then push across the time counter wrap.
        repeat (3) apply_stimulus(4'b0000, 1'b0);
        guard = 0;
        while (time_now != 8'd255 && guard < 400) begin
            apply_stimulus(4'b0000, 1'b0);
            guard++;
        end
        check_val("wrap_reached_255", 64'(time_now), 64'd255);
        apply_stimulus(4'b0000, 1'b1);
        check_val("wrap_time_zero", 64'(time_now), 64'd0);
        apply_stimulus(4'b0000, 1'b1);
        check_val("wrap_stamp_255", 64'(stamp_of(0)), 64'd255);
        apply_stimulus(4'b0000, 1'b0);
        check_val("wrap_stamp_0", 64'(stamp_of(0)), 64'd0);

        // Asynchronous reset in the middle of traffic.
        repeat (3) apply_stimulus(4'b1111, 1'b1);
        check_val("pre_reset_count", 64'(fifo_count), 64'd3);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_output();
        @(negedge clk);
        rst_n = 1;
        apply_stimulus(4'b0000, 1'b0);
        check_val("post_reset_time", 64'(time_now), 64'd1);
        check_val("post_reset_count", 64'(fifo_count), 64'd0);

        // Randomized traffic in phases of differing lane pressure.
        for (int b = 0; b < 10; b++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int c = 0; c < 40; c++) begin
                logic [3:0] lv;
                if (mode == 1) lv = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
                else if (mode == 2) lv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                else lv = 4'($urandom);
                apply_stimulus(lv, 1'($urandom_range(0, 1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
